stoch_to_bin: RTL and testbench
===============================

STOCH_TO_BIN -- requirements
Module: stoch_to_bin

Interface
REQ-001 Parameter N, default 8: result width; the window length is 2^N enabled samples.
REQ-002 Parameter CONT, default 0: 0 = one window per START; 1 = windows restart automatically back-to-back.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset; synchronous, active-low (RST=0 at a posedge resets).
REQ-005 START  input  1  request to begin a new accumulation window; sampled only in IDLE.
REQ-006 EN  input  1  sample qualifier; IN is counted only on cycles with EN=1.
REQ-007 IN  input  1  unipolar stochastic bitstream input.
REQ-008 Q  output  N  binary estimate of the last completed window; feeds the downstream N-bit DFF register stage.
REQ-009 VALID  output  1  one-cycle pulse marking a fresh Q.
REQ-010 BUSY  output  1  high while a window is in progress (state ACCUM).

Function
REQ-011 The FSM states SHALL be IDLE and ACCUM, and reset SHALL enter IDLE.
REQ-012 In IDLE, START=1 at a posedge SHALL move the FSM to ACCUM and clear the ones-counter (N+1 bits) and the sample-counter (N bits).
REQ-013 In ACCUM, each posedge with EN=1 SHALL add IN to the ones-counter and increment the sample-counter.
REQ-014 In ACCUM, each posedge with EN=0 SHALL hold both counters (pause); there is no timeout.
REQ-015 The last sample SHALL be the enabled cycle on which the sample-counter equals 2^N-1, and that sample SHALL be included in the result.
REQ-016 On the posedge that takes the last sample, Q SHALL load min(ones+IN, 2^N-1), saturating the all-ones count 2^N to 2^N-1.
REQ-017 On that same posedge, VALID SHALL go high for exactly one cycle.
REQ-018 On that same posedge with CONT=0, the FSM SHALL return to IDLE.
REQ-019 On that same posedge with CONT=1, the FSM SHALL stay in ACCUM with both counters cleared, so the next enabled cycle is sample 0 of a new window.
REQ-020 Result latency SHALL be 0 cycles after the last sample: Q and VALID are updated by that same posedge.
REQ-021 A START seen in IDLE in the cycle VALID is high SHALL begin a new window, giving back-to-back windows with one IDLE cycle.
REQ-022 START in ACCUM SHALL be ignored and SHALL NOT restart the window.
REQ-023 Q SHALL hold its value between completions and SHALL NOT change during accumulation.
REQ-024 BUSY SHALL equal (state==ACCUM), registered.

Reset
REQ-025 When RST=0 at a posedge: state=IDLE, both counters=0, Q=0, VALID=0, BUSY=0.
REQ-026 Reset SHALL override START and EN in the same cycle.
REQ-027 A reset mid-window SHALL discard the partial count and SHALL NOT produce a VALID pulse.
REQ-028 After RST returns high, no window SHALL begin until START, unless CONT=1.
REQ-029 With CONT=1, the first cycle after reset release SHALL enter ACCUM without START.

Verification (N=4, 16-sample window)
REQ-030 START, then 16 cycles EN=1 IN=1 -> VALID pulses on the 16th sample posedge; Q=15 (saturated); BUSY falls at the same posedge.
REQ-031 START, then 16 cycles EN=1 IN=0 -> Q=0 with a VALID pulse; START held again in the VALID cycle -> BUSY high the next cycle.
REQ-032 START, then IN alternating 1,0 with EN toggling every other cycle (32 cycles, 16 enabled samples, 8 of them ones) -> Q=8; VALID occurs after the 32nd cycle only.
REQ-033 Reset pulse after 10 samples of IN=1 -> Q=0 and no VALID; then START plus 16 samples with 5 ones -> Q=5.
REQ-034 CONT=1, IN=1 continuously after reset release -> VALID every 16 cycles, Q=15, BUSY never drops.
REQ-035 START pulsed during ACCUM at sample 7 -> ignored; VALID occurs still at sample 16 of the original window.

Source files
------------

// File: rtl/stoch_to_bin.sv
// Stochastic-to-binary converter: counts ones of a unipolar bitstream over a
// window of 2^N enabled samples and publishes the saturated count on Q.
module stoch_to_bin #(
    parameter int N    = 8,
    parameter int CONT = 0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic         EN,
    input  logic         IN,
    output logic [N-1:0] Q,
    output logic         VALID,
    output logic         BUSY
);

    // Handshake: START is a request accepted only in IDLE (ignored in ACCUM);
    // VALID is a single-cycle pulse with no backpressure, Q holds until the next one.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N:0]   ones_q, ones_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] q_q, q_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic [N:0]   sum;
    logic         last_sample;

    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        valid_d     = 1'b0;
        sum         = ones_q + {{N{1'b0}}, IN};
        last_sample = EN && (cnt_q == {N{1'b1}});

        case (state_q)
            IDLE: begin
                if (START || (CONT != 0)) begin
                    state_d = ACCUM;
                    ones_d  = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (last_sample) begin
                    // An all-ones window counts 2^N, which does not fit in N bits.
                    q_d     = sum[N] ? {N{1'b1}} : sum[N-1:0];
                    valid_d = 1'b1;
                    ones_d  = '0;
                    cnt_d   = '0;
                    state_d = (CONT != 0) ? ACCUM : IDLE;
                end else if (EN) begin
                    ones_d = sum;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ACCUM);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            ones_q  <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign Q     = q_q;
    assign VALID = valid_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_stoch_to_bin.sv
// Directed bench for stoch_to_bin with N=4: one single-shot instance and one
// continuous-mode instance sharing the clock.
module tb_stoch_to_bin;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RST, START, EN, IN;
    logic [N-1:0] Q;
    logic         VALID, BUSY;
    logic         rst_c, start_c, en_c, in_c;
    logic [N-1:0] q_c;
    logic         valid_c, busy_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    stoch_to_bin #(.N(N), .CONT(0)) dut (
        .CLK(CLK), .RST(RST), .START(START), .EN(EN), .IN(IN),
        .Q(Q), .VALID(VALID), .BUSY(BUSY)
    );

    stoch_to_bin #(.N(N), .CONT(1)) dut_c (
        .CLK(CLK), .RST(rst_c), .START(start_c), .EN(en_c), .IN(in_c),
        .Q(q_c), .VALID(valid_c), .BUSY(busy_c)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b0; START = 1'b0; EN = 1'b0; IN = 1'b0;
        rst_c = 1'b0; start_c = 1'b0; en_c = 1'b0; in_c = 1'b0;

        // reset, with START/EN asserted to show reset wins
        START = 1'b1; EN = 1'b1; IN = 1'b1;
        tick(); tick();
        chk("rst_q", Q, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_busy", BUSY, 0);
        START = 1'b0; EN = 1'b0; IN = 1'b0;

        // all-ones window saturates to 15
        RST = 1'b1; START = 1'b1;
        tick();
        chk("ones_start_busy", BUSY, 1);
        START = 1'b0; EN = 1'b1; IN = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("ones_mid_valid", VALID, 0);
            chk("ones_mid_busy", BUSY, 1);
            chk("ones_mid_q_hold", Q, 0);
        end
        tick();
        chk("ones_valid", VALID, 1);
        chk("ones_q_sat", Q, 15);
        chk("ones_busy_fall", BUSY, 0);
        EN = 1'b0;
        tick();
        chk("ones_valid_pulse", VALID, 0);
        chk("ones_q_hold", Q, 15);

        // all-zeros window, restart in the VALID cycle
        START = 1'b1;
        tick();
        START = 1'b0; EN = 1'b1; IN = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("zeros_pre_valid", VALID, 0);
        chk("zeros_pre_q_hold", Q, 15);
        tick();
        chk("zeros_valid", VALID, 1);
        chk("zeros_q", Q, 0);
        chk("zeros_busy", BUSY, 0);
        START = 1'b1; EN = 1'b0;
        tick();
        chk("b2b_busy", BUSY, 1);
        chk("b2b_valid", VALID, 0);
        START = 1'b0;

        // EN toggling; paused cycles drive IN=1 which must not count
        for (int k = 0; k < 32; k++) begin
            EN = k[0];
            IN = (k % 2 == 0) ? 1'b1 : (((k / 2) % 2) == 0);
            tick();
            if (k < 31) chk("alt_no_valid", VALID, 0);
        end
        chk("alt_valid", VALID, 1);
        chk("alt_q", Q, 8);
        chk("alt_busy", BUSY, 0);

        // mid-window reset discards partial count
        EN = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0; EN = 1'b1; IN = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        RST = 1'b0;
        tick();
        chk("midrst_q", Q, 0);
        chk("midrst_valid", VALID, 0);
        chk("midrst_busy", BUSY, 0);
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_no_busy", BUSY, 0);
            chk("idle_no_valid", VALID, 0);
        end
        START = 1'b1; EN = 1'b0;
        tick();
        START = 1'b0; EN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            IN = (i % 3 == 0) && (i < 15);
            tick();
        end
        chk("five_valid", VALID, 1);
        chk("five_q", Q, 5);

        // START inside ACCUM is ignored
        EN = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0; EN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            IN = (i < 11);
            START = (i == 7);
            tick();
            if (i < 15) begin
                chk("ign_no_valid", VALID, 0);
                chk("ign_busy", BUSY, 1);
            end
        end
        START = 1'b0;
        chk("ign_valid", VALID, 1);
        chk("ign_q", Q, 11);
        EN = 1'b0;
        tick();

        // continuous mode: enters ACCUM without START after reset release
        rst_c = 1'b1; en_c = 1'b1; in_c = 1'b1;
        tick();
        chk("cont_busy_enter", busy_c, 1);
        chk("cont_q_init", q_c, 0);
        for (int i = 0; i < 48; i++) begin
            tick();
            chk("cont_valid", valid_c, (i % 16 == 15) ? 1 : 0);
            chk("cont_busy", busy_c, 1);
            if (i >= 15) chk("cont_q", q_c, 15);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
